// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle FETCH/DECODE/EXEC control unit for the 8-bit CPU.
// Outputs are a decode of the registered state. RAM-gated strobes are additionally
// qualified by ip_mem_ready. The ALU flags are latched internally.
// Ports: clock/ip_clear/ip_clock_enable are control inputs. ip_IR, ip_carry, ip_zero and
// ip_mem_ready carry datapath status. op_MUX* are the datapath mux selects, op_en_* and
// op_RAM_we are the register/RAM strobes, and op_ALU_sel is the ALU function.
// op_carry_flag, op_zero_flag, op_halted and op_state report internal state.
module cpu_control_fsm #(
  parameter int DATA_W    = 8,
  parameter int ALU_SEL_W = 5
) (
  input  logic                 clock,
  input  logic                 ip_clear,
  input  logic                 ip_clock_enable,
  input  logic [DATA_W-1:0]    ip_IR,
  input  logic                 ip_carry,
  input  logic                 ip_zero,
  input  logic                 ip_mem_ready,
  output logic                 op_MUXa,
  output logic                 op_MUXb,
  output logic                 op_MUXc,
  output logic                 op_en_da,
  output logic                 op_en_pc,
  output logic                 op_en_in,
  output logic                 op_en_out,
  output logic                 op_RAM_we,
  output logic [ALU_SEL_W-1:0] op_ALU_sel,
  output logic                 op_carry_flag,
  output logic                 op_zero_flag,
  output logic                 op_halted,
  output logic [1:0]           op_state
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic [3:0] OP_LOAD   = 4'b0000;
  localparam logic [3:0] OP_AND    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_ADDC   = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_SUBB   = 4'b0111;
  localparam logic [3:0] OP_JUMP   = 4'b1000;
  localparam logic [3:0] OP_JCC    = 4'b1001;
  localparam logic [3:0] OP_INPUT  = 4'b1010;
  localparam logic [3:0] OP_STORE  = 4'b1101;
  localparam logic [3:0] OP_OUTPUT = 4'b1110;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  localparam logic [ALU_SEL_W-1:0] ALU_PASS_B = ALU_SEL_W'(0);
  localparam logic [ALU_SEL_W-1:0] ALU_ADD    = ALU_SEL_W'(1);
  localparam logic [ALU_SEL_W-1:0] ALU_ADDC   = ALU_SEL_W'(2);
  localparam logic [ALU_SEL_W-1:0] ALU_SUB    = ALU_SEL_W'(3);
  localparam logic [ALU_SEL_W-1:0] ALU_SUBB   = ALU_SEL_W'(4);
  localparam logic [ALU_SEL_W-1:0] ALU_AND    = ALU_SEL_W'(5);
  localparam logic [ALU_SEL_W-1:0] ALU_XOR    = ALU_SEL_W'(6);

  state_t state, next_state;
  logic   carry_q, zero_q;
  logic   flag_upd;
  logic   mem_op;
  logic   jcc_taken;
  logic   mux_a, mux_b, mux_c, en_da, en_pc, en_in, en_out, ram_we;
  logic [ALU_SEL_W-1:0] alu_sel;

  logic [3:0] opcode;
  assign opcode = ip_IR[DATA_W-1:DATA_W-4];

  // The low operand bits only address the PC/RAM in the datapath.
  logic unused_operand;
  assign unused_operand = ^ip_IR[DATA_W-7:0];

  // Conditional jump: top operand bit picks carry over zero, the next bit inverts.
  assign jcc_taken = (ip_IR[DATA_W-5] ? carry_q : zero_q) ^ ip_IR[DATA_W-6];

  always_ff @(posedge clock) begin
    if (ip_clear) begin
      state   <= FETCH;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (ip_clock_enable) begin
      state <= next_state;
      if (flag_upd) begin
        carry_q <= ip_carry;
        zero_q  <= ip_zero;
      end
    end
  end

  always_comb begin
    next_state = state;
    mux_a      = 1'b0;
    mux_b      = 1'b0;
    mux_c      = 1'b0;
    en_da      = 1'b0;
    en_pc      = 1'b0;
    en_in      = 1'b0;
    en_out     = 1'b0;
    ram_we     = 1'b0;
    alu_sel    = ALU_PASS_B;
    flag_upd   = 1'b0;
    mem_op     = 1'b0;
    case (state)
      FETCH: begin
        if (ip_mem_ready) begin
          en_in      = 1'b1;
          en_pc      = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: next_state = EXEC;
      EXEC: begin
        next_state = FETCH;
        case (opcode)
          OP_LOAD: mem_op = 1'b1;
          OP_AND:  begin mem_op = 1'b1; alu_sel = ALU_AND;  end
          OP_XOR:  begin mem_op = 1'b1; alu_sel = ALU_XOR;  end
          OP_ADD:  begin mem_op = 1'b1; alu_sel = ALU_ADD;  end
          OP_ADDC: begin mem_op = 1'b1; alu_sel = ALU_ADDC; end
          OP_SUB:  begin mem_op = 1'b1; alu_sel = ALU_SUB;  end
          OP_SUBB: begin mem_op = 1'b1; alu_sel = ALU_SUBB; end
          OP_JUMP: begin mux_c = 1'b1; en_pc = 1'b1; end
          OP_JCC: begin
            if (jcc_taken) begin
              mux_c = 1'b1;
              en_pc = 1'b1;
            end
          end
          OP_INPUT: begin mux_b = 1'b1; en_da = 1'b1; end
          OP_STORE: begin
            // Write strobe is held for the whole wait, including the accepting cycle.
            mux_a  = 1'b1;
            ram_we = 1'b1;
            if (!ip_mem_ready) next_state = EXEC;
          end
          OP_OUTPUT: en_out = 1'b1;
          OP_HALT:   next_state = HALT;
          default: ;
        endcase
        // ALU ops read their operand from RAM and retire on the ready cycle.
        if (mem_op) begin
          mux_a = 1'b1;
          if (ip_mem_ready) begin
            en_da    = 1'b1;
            flag_upd = 1'b1;
          end else begin
            next_state = EXEC;
          end
        end
      end
      HALT: next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  // Stall freezes the strobes; mux selects keep their decoded values.
  assign op_MUXa       = mux_a;
  assign op_MUXb       = mux_b;
  assign op_MUXc       = mux_c;
  assign op_ALU_sel    = alu_sel;
  assign op_en_da      = en_da  & ip_clock_enable;
  assign op_en_pc      = en_pc  & ip_clock_enable;
  assign op_en_in      = en_in  & ip_clock_enable;
  assign op_en_out     = en_out & ip_clock_enable;
  assign op_RAM_we     = ram_we & ip_clock_enable;
  assign op_carry_flag = carry_q;
  assign op_zero_flag  = zero_q;
  assign op_halted     = (state == HALT);
  assign op_state      = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed vector bench for cpu_control_fsm.
// Each step drives inputs for one cycle and compares all outputs before the next edge.
// Ports: none (top-level bench).
module tb_cpu_control_fsm;

  logic       clock = 1'b0;
  logic       ip_clear, ip_clock_enable, ip_carry, ip_zero, ip_mem_ready;
  logic [7:0] ip_IR;
  logic       op_MUXa, op_MUXb, op_MUXc, op_en_da, op_en_pc, op_en_in, op_en_out, op_RAM_we;
  logic [4:0] op_ALU_sel;
  logic       op_carry_flag, op_zero_flag, op_halted;
  logic [1:0] op_state;

  int tests_run = 0;
  int tests_failed = 0;

  // en field order {da, pc, in, out, we}; mux field order {a, b, c}
  localparam logic [4:0] EN_NONE = 5'b00000, EN_FETCH = 5'b01100, EN_DA = 5'b10000,
                         EN_PC = 5'b01000, EN_OUT = 5'b00010, EN_WE = 5'b00001;
  localparam logic [2:0] MX_NONE = 3'b000, MX_A = 3'b100, MX_B = 3'b010, MX_C = 3'b001;

  typedef struct {
    string      name;
    logic       clr, ce;
    logic [7:0] ir;
    logic       c, z, rdy;
    logic [1:0] st;
    logic       h, cf, zf;
    logic [2:0] mux;
    logic [4:0] en;
    logic [4:0] alu;
  } vec_t;

  vec_t tbl[$];

  cpu_control_fsm #(.DATA_W(8), .ALU_SEL_W(5)) dut (
    .clock(clock), .ip_clear(ip_clear), .ip_clock_enable(ip_clock_enable),
    .ip_IR(ip_IR), .ip_carry(ip_carry), .ip_zero(ip_zero), .ip_mem_ready(ip_mem_ready),
    .op_MUXa(op_MUXa), .op_MUXb(op_MUXb), .op_MUXc(op_MUXc),
    .op_en_da(op_en_da), .op_en_pc(op_en_pc), .op_en_in(op_en_in),
    .op_en_out(op_en_out), .op_RAM_we(op_RAM_we), .op_ALU_sel(op_ALU_sel),
    .op_carry_flag(op_carry_flag), .op_zero_flag(op_zero_flag),
    .op_halted(op_halted), .op_state(op_state)
  );

  always #5 clock = ~clock;

  task automatic row(input string n, input logic clr, input logic ce, input logic [7:0] ir,
                     input logic c, input logic z, input logic rdy, input logic [1:0] st,
                     input logic h, input logic cf, input logic zf, input logic [2:0] mux,
                     input logic [4:0] en, input logic [4:0] alu);
    vec_t v;
    v.name = n; v.clr = clr; v.ce = ce; v.ir = ir; v.c = c; v.z = z; v.rdy = rdy;
    v.st = st; v.h = h; v.cf = cf; v.zf = zf; v.mux = mux; v.en = en; v.alu = alu;
    tbl.push_back(v);
  endtask

  // Drive one vector (shortly after a rising edge), compare before the next edge, then advance.
  task automatic step(input vec_t v);
    logic [17:0] got, exp;
    ip_clear = v.clr; ip_clock_enable = v.ce; ip_IR = v.ir;
    ip_carry = v.c; ip_zero = v.z; ip_mem_ready = v.rdy;
    #4;
    got = {op_state, op_halted, op_carry_flag, op_zero_flag, op_MUXa, op_MUXb, op_MUXc,
           op_en_da, op_en_pc, op_en_in, op_en_out, op_RAM_we, op_ALU_sel};
    exp = {v.st, v.h, v.cf, v.zf, v.mux, v.en, v.alu};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got st=%0d h=%b cf=%b zf=%b mux=%b en=%b alu=%0d, want st=%0d h=%b cf=%b zf=%b mux=%b en=%b alu=%0d",
               v.name, got[17:16], got[15], got[14], got[13], got[12:10], got[9:5], got[4:0],
               exp[17:16], exp[15], exp[14], exp[13], exp[12:10], exp[9:5], exp[4:0]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic go(input string n, input logic clr, input logic ce, input logic [7:0] ir,
                    input logic c, input logic z, input logic rdy, input logic [1:0] st,
                    input logic h, input logic cf, input logic zf, input logic [2:0] mux,
                    input logic [4:0] en, input logic [4:0] alu);
    vec_t v;
    v.name = n; v.clr = clr; v.ce = ce; v.ir = ir; v.c = c; v.z = z; v.rdy = rdy;
    v.st = st; v.h = h; v.cf = cf; v.zf = zf; v.mux = mux; v.en = en; v.alu = alu;
    step(v);
  endtask

  initial begin
    //   name           clr ce ir     c  z  rdy st h cf zf mux     en        alu
    row("reset",         1, 1, 8'h00, 0, 0, 1, 0, 0, 0, 0, MX_NONE, EN_FETCH, 0);
    row("add_fetch",     0, 1, 8'h40, 1, 0, 1, 0, 0, 0, 0, MX_NONE, EN_FETCH, 0);
    row("add_decode",    0, 1, 8'h40, 1, 0, 1, 1, 0, 0, 0, MX_NONE, EN_NONE,  0);
    row("add_exec",      0, 1, 8'h40, 1, 0, 1, 2, 0, 0, 0, MX_A,    EN_DA,    1);
    row("jc_fetch",      0, 1, 8'h98, 0, 1, 1, 0, 0, 1, 0, MX_NONE, EN_FETCH, 0);
    row("jc_decode",     0, 1, 8'h98, 0, 1, 1, 1, 0, 1, 0, MX_NONE, EN_NONE,  0);
    row("jc_exec",       0, 1, 8'h98, 0, 1, 1, 2, 0, 1, 0, MX_C,    EN_PC,    0);
    row("jz_fetch",      0, 1, 8'h90, 0, 1, 1, 0, 0, 1, 0, MX_NONE, EN_FETCH, 0);
    row("jz_decode",     0, 1, 8'h90, 0, 1, 1, 1, 0, 1, 0, MX_NONE, EN_NONE,  0);
    row("jz_exec",       0, 1, 8'h90, 0, 1, 1, 2, 0, 1, 0, MX_NONE, EN_NONE,  0);
    row("jnz_fetch",     0, 1, 8'h94, 0, 1, 1, 0, 0, 1, 0, MX_NONE, EN_FETCH, 0);
    row("jnz_decode",    0, 1, 8'h94, 0, 1, 1, 1, 0, 1, 0, MX_NONE, EN_NONE,  0);
    row("jnz_exec",      0, 1, 8'h94, 0, 1, 1, 2, 0, 1, 0, MX_C,    EN_PC,    0);
    row("jnc_fetch",     0, 1, 8'h9C, 0, 1, 1, 0, 0, 1, 0, MX_NONE, EN_FETCH, 0);
    row("jnc_decode",    0, 1, 8'h9C, 0, 1, 1, 1, 0, 1, 0, MX_NONE, EN_NONE,  0);
    row("jnc_exec",      0, 1, 8'h9C, 0, 1, 1, 2, 0, 1, 0, MX_NONE, EN_NONE,  0);
    row("input_fetch",   0, 1, 8'hA5, 0, 1, 1, 0, 0, 1, 0, MX_NONE, EN_FETCH, 0);
    row("input_decode",  0, 1, 8'hA5, 0, 1, 1, 1, 0, 1, 0, MX_NONE, EN_NONE,  0);
    row("input_exec",    0, 1, 8'hA5, 0, 1, 1, 2, 0, 1, 0, MX_B,    EN_DA,    0);
    row("output_fetch",  0, 1, 8'hE0, 0, 1, 1, 0, 0, 1, 0, MX_NONE, EN_FETCH, 0);
    row("output_decode", 0, 1, 8'hE0, 0, 1, 1, 1, 0, 1, 0, MX_NONE, EN_NONE,  0);
    row("output_exec",   0, 1, 8'hE0, 0, 1, 1, 2, 0, 1, 0, MX_NONE, EN_OUT,   0);
    row("jump_fetch",    0, 1, 8'h8F, 0, 1, 1, 0, 0, 1, 0, MX_NONE, EN_FETCH, 0);
    row("jump_decode",   0, 1, 8'h8F, 0, 1, 1, 1, 0, 1, 0, MX_NONE, EN_NONE,  0);
    row("jump_exec",     0, 1, 8'h8F, 0, 1, 1, 2, 0, 1, 0, MX_C,    EN_PC,    0);
    row("xor_fetch",     0, 1, 8'h30, 0, 1, 1, 0, 0, 1, 0, MX_NONE, EN_FETCH, 0);
    row("xor_decode",    0, 1, 8'h30, 0, 1, 1, 1, 0, 1, 0, MX_NONE, EN_NONE,  0);
    row("xor_exec",      0, 1, 8'h30, 0, 1, 1, 2, 0, 1, 0, MX_A,    EN_DA,    6);
    row("load_fetch",    0, 1, 8'h00, 1, 0, 1, 0, 0, 0, 1, MX_NONE, EN_FETCH, 0);
    row("load_decode",   0, 1, 8'h00, 1, 0, 1, 1, 0, 0, 1, MX_NONE, EN_NONE,  0);
    row("load_wait1",    0, 1, 8'h00, 1, 0, 0, 2, 0, 0, 1, MX_A,    EN_NONE,  0);
    row("load_wait2",    0, 1, 8'h00, 1, 0, 0, 2, 0, 0, 1, MX_A,    EN_NONE,  0);
    row("load_wait3",    0, 1, 8'h00, 1, 0, 0, 2, 0, 0, 1, MX_A,    EN_NONE,  0);
    row("load_wait4",    0, 1, 8'h00, 1, 0, 0, 2, 0, 0, 1, MX_A,    EN_NONE,  0);
    row("load_ready",    0, 1, 8'h00, 1, 0, 1, 2, 0, 0, 1, MX_A,    EN_DA,    0);
    row("fetch_wait1",   0, 1, 8'h70, 0, 1, 0, 0, 0, 1, 0, MX_NONE, EN_NONE,  0);
    row("fetch_wait2",   0, 1, 8'h70, 0, 1, 0, 0, 0, 1, 0, MX_NONE, EN_NONE,  0);

    ip_clear = 1'b1; ip_clock_enable = 1'b1; ip_IR = 8'h00;
    ip_carry = 1'b0; ip_zero = 1'b0; ip_mem_ready = 1'b1;
    @(posedge clock);
    #1;
    foreach (tbl[i]) step(tbl[i]);

    // Stall in DECODE, then in EXEC with live ALU flags that must not be captured.
    go("subb_fetch", 0, 1, 8'h70, 0, 1, 1, 0, 0, 1, 0, MX_NONE, EN_FETCH, 0);
    for (int i = 0; i < 5; i++)
      go("stall_decode", 0, 0, 8'h70, 0, 1, 1, 1, 0, 1, 0, MX_NONE, EN_NONE, 0);
    go("resume_decode", 0, 1, 8'h70, 0, 1, 1, 1, 0, 1, 0, MX_NONE, EN_NONE, 0);
    go("stall_exec1",   0, 0, 8'h70, 0, 1, 1, 2, 0, 1, 0, MX_A,    EN_NONE, 4);
    go("stall_exec2",   0, 0, 8'h70, 0, 1, 1, 2, 0, 1, 0, MX_A,    EN_NONE, 4);
    go("subb_exec",     0, 1, 8'h70, 0, 1, 1, 2, 0, 1, 0, MX_A,    EN_DA,   4);

    // HALT is sticky until ip_clear, which also clears the flags.
    go("halt_fetch",  0, 1, 8'hF0, 1, 0, 1, 0, 0, 0, 1, MX_NONE, EN_FETCH, 0);
    go("halt_decode", 0, 1, 8'hF0, 1, 0, 1, 1, 0, 0, 1, MX_NONE, EN_NONE,  0);
    go("halt_exec",   0, 1, 8'hF0, 1, 0, 1, 2, 0, 0, 1, MX_NONE, EN_NONE,  0);
    for (int i = 0; i < 10; i++)
      go("halted", 0, 1, 8'hF0, 1, 0, 1, 3, 1, 0, 1, MX_NONE, EN_NONE, 0);
    go("halt_clear",  1, 1, 8'hF0, 1, 0, 1, 3, 1, 0, 1, MX_NONE, EN_NONE,  0);

    // STORE completes normally, then a second STORE is aborted by reset mid-wait.
    go("store_fetch",  0, 1, 8'hD0, 1, 0, 1, 0, 0, 0, 0, MX_NONE, EN_FETCH, 0);
    go("store_decode", 0, 1, 8'hD0, 1, 0, 1, 1, 0, 0, 0, MX_NONE, EN_NONE,  0);
    go("store_wait1",  0, 1, 8'hD0, 1, 0, 0, 2, 0, 0, 0, MX_A,    EN_WE,    0);
    go("store_wait2",  0, 1, 8'hD0, 1, 0, 0, 2, 0, 0, 0, MX_A,    EN_WE,    0);
    go("store_accept", 0, 1, 8'hD0, 1, 0, 1, 2, 0, 0, 0, MX_A,    EN_WE,    0);
    go("store2_fetch", 0, 1, 8'hD0, 1, 0, 1, 0, 0, 0, 0, MX_NONE, EN_FETCH, 0);
    go("store2_decode",0, 1, 8'hD0, 1, 0, 1, 1, 0, 0, 0, MX_NONE, EN_NONE,  0);
    go("store2_wait",  0, 1, 8'hD0, 1, 0, 0, 2, 0, 0, 0, MX_A,    EN_WE,    0);
    go("store2_clear", 1, 1, 8'hD0, 1, 0, 0, 2, 0, 0, 0, MX_A,    EN_WE,    0);
    go("after_abort",  0, 1, 8'hD0, 1, 0, 0, 0, 0, 0, 0, MX_NONE, EN_NONE,  0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control unit for the 8-bit CPU. It supersedes the single-cycle combinational decoder.
- Sequences FETCH/DECODE/EXEC through a state machine, waits on RAM readiness, and latches ALU flags internally.
- Adds ADDC/SUBB, XOR, STORE, HALT and a clock-enable stall.
- Drives the datapath muxes, register enables, RAM write and the ALU select.

Parameters:
DATA_W, 8, instruction/data width; must be >= 8. Opcode = IR[DATA_W-1:DATA_W-4]; operand = IR[DATA_W-5:0].
ALU_SEL_W, 5, width of the ALU select bus; must be >= 4. Unused MSBs are driven 0.

Ports:
clock  input  1  system clock, rising edge
ip_clear  input  1  synchronous active-high reset
ip_clock_enable  input  1  1 = advance; 0 = freeze state and flags, force every enable/strobe output to 0
ip_IR  input  DATA_W  instruction register contents (valid from DECODE onward)
ip_carry  input  1  ALU carry out, combinational
ip_zero  input  1  ALU zero out, combinational
ip_mem_ready  input  1  RAM read data valid / write accepted
op_MUXa  output  1  RAM address select: 0 = PC, 1 = IR operand
op_MUXb  output  1  ACC input select: 0 = ALU result, 1 = input port
op_MUXc  output  1  PC load select: 0 = PC+1, 1 = IR operand
op_en_da  output  1  accumulator write enable
op_en_pc  output  1  PC write enable
op_en_in  output  1  IR load enable
op_en_out  output  1  output-port latch strobe
op_RAM_we  output  1  RAM write enable
op_ALU_sel  output  ALU_SEL_W  ALU function: 0 PASS_B, 1 ADD, 2 ADDC, 3 SUB, 4 SUBB, 5 AND, 6 XOR
op_carry_flag  output  1  latched carry
op_zero_flag  output  1  latched zero
op_halted  output  1  1 while in HALT
op_state  output  2  0 FETCH, 1 DECODE, 2 EXEC, 3 HALT

Behaviour:
Reset and clock enable:
- Synchronous reset, active-high. ip_clear sampled high at a rising edge gives: state = FETCH, both flags = 0, op_halted = 0.
- Reset overrides ip_clock_enable and aborts any in-progress instruction, including a pending memory wait.
- All outputs are a registered-state decode (Moore, except the ready-qualified strobes below). During reset and for the first FETCH cycle, all enables are 0 except the FETCH strobes; op_ALU_sel = 0.
- ip_clock_enable = 0: state and flags hold; op_en_da, op_en_pc, op_en_in, op_en_out and op_RAM_we are forced 0; mux selects keep their state-decoded values.

FETCH:
- MUXa = 0. While ip_mem_ready = 0, all enables are 0 and the FSM stays in FETCH (unbounded wait).
- With ip_mem_ready = 1: op_en_in = 1, op_en_pc = 1, MUXc = 0, then go to DECODE. IR loads and PC increments on the same edge.

DECODE:
- One cycle, no enables, then go to EXEC.

EXEC: one cycle unless memory-gated; returns to FETCH unless HALT. Per opcode:
- 0000 LOAD: MUXa = 1, MUXb = 0, ALU = PASS_B. Waits for ip_mem_ready; en_da = 1 on the ready cycle.
- 0001 AND: like LOAD with ALU = AND. 0011 XOR: ALU = XOR.
- 0100 ADD, 0101 ADDC, 0110 SUB, 0111 SUBB: like LOAD with the matching ALU code.
- ADDC/SUBB consume op_carry_flag inside the ALU; this block only selects the function.
- 1000 JUMP: MUXc = 1, en_pc = 1. No memory wait.
- 1001 conditional jump:
  - IR bit DATA_W-5 = 0 selects the zero flag; 1 selects the carry flag.
  - IR bit DATA_W-6 = 1 inverts the condition.
  - Condition true: MUXc = 1, en_pc = 1. False: no enables.
  - Operand bits used as the jump address are the full operand field.
- 1010 INPUT: MUXb = 1, en_da = 1. No flag update.
- 1101 STORE: MUXa = 1, RAM_we = 1 held until ip_mem_ready = 1.
- 1110 OUTPUT: en_out = 1 for one cycle.
- 1111 HALT: go to HALT.
- Other opcodes: NOP, no enables.

Flags:
- Flags update only on the EXEC edge where en_da = 1 for ALU ops (AND, XOR, ADD, ADDC, SUB, SUBB, LOAD): carry_q <= ip_carry, zero_q <= ip_zero.
- AND, XOR and LOAD also update carry from ip_carry; the ALU drives carry 0 for them.
- Jumps, INPUT, STORE, OUTPUT and NOP preserve both flags.

HALT:
- All enables 0, op_halted = 1. Only ip_clear exits HALT.

Invariants:
- At most one of en_in / en_da / RAM_we is asserted per cycle.
- Each instruction issues exactly one en_pc increment in FETCH, plus at most one load in EXEC.

Test Plan:
1. Reset: ip_clear = 1 for 2 cycles, mem_ready = 1 -> op_state = 0, flags 0, op_halted = 0. First post-reset edge asserts en_in = 1 and en_pc = 1.
2. ADD 8'b01000000 with ip_carry = 1, ip_zero = 0, mem_ready = 1 -> states 0,1,2,0 in 3 cycles. EXEC gives op_ALU_sel = 1, MUXa = 1, en_da = 1. Afterwards op_carry_flag = 1, op_zero_flag = 0.
3. Conditional jumps, starting from carry_flag = 1, zero_flag = 0:
   - 8'b10011000 JC: en_pc = 1, MUXc = 1.
   - 8'b10010000 JZ: no en_pc.
   - 8'b10010100 JNZ: en_pc = 1.
   - 8'b10011100 JNC: no en_pc.
   - All four leave the flags unchanged.
4. Memory stall: LOAD 8'b00000000 with mem_ready held 0 for 4 EXEC cycles -> en_da = 0 throughout, state stays 2. en_da = 1 exactly on the cycle mem_ready rises, then FETCH.
5. Clock enable: ip_clock_enable = 0 for 5 cycles mid-DECODE -> op_state frozen at 1, all enables 0. On re-enable, EXEC proceeds normally.
6. HALT 8'b11110000 -> op_state = 3, op_halted = 1, no enables for 10 cycles despite mem_ready = 1. ip_clear pulse -> FETCH, op_halted = 0. ip_clear asserted mid-STORE wait -> RAM_we drops and state = FETCH on the next edge.
